// File: rtl/otl_unpack.sv
// Word-to-sample unpacker: buffers 32-bit host words in a small FIFO and
// streams two 12-bit samples per word (high half first) with a frame strobe.
module otl_unpack #(
  parameter int DEPTH    = 4,
  parameter int SAMPLE_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [SAMPLE_W-1:0]      data_o,
  output logic                     frame_o,
  output logic                     pad_err_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  logic [31:0]         mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  state_t              state_q;
  logic [SAMPLE_W-1:0] hold_q, data_q;
  logic                frame_q, pad_err_q;
  logic                push, pop;
  logic [31:0]         rd_word;

  function automatic logic pad_nonzero(input logic [31:0] w);
    return |{w[31:28], w[15:12]};
  endfunction

  assign ready_o = ~rst & (count_q != CW'(DEPTH));
  assign push    = valid_i & ready_o;
  // HI is the only state that does not need a fresh word on this edge.
  assign pop     = (state_q != HI) & (count_q != '0);
  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Sample sequencer: state and registered outputs move together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      frame_q   <= 1'b0;
      pad_err_q <= 1'b0;
    end else begin
      if (pop) begin
        state_q <= HI;
        data_q  <= rd_word[27:16];
        hold_q  <= rd_word[11:0];
        frame_q <= 1'b1;
        if (pad_nonzero(rd_word)) pad_err_q <= 1'b1;
      end else if (state_q == HI) begin
        state_q <= LO;
        data_q  <= hold_q;
        frame_q <= 1'b1;
      end else begin
        state_q <= IDLE;
        data_q  <= '0;
        frame_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign frame_o   = frame_q;
  assign pad_err_o = pad_err_q;
  assign level_o   = count_q;

endmodule

// File: tb/tb_otl_unpack.sv
// Bench for otl_unpack: a directed vector table plus model-checked
// sequences for FIFO-full, underflow gap and reset mid-burst.
module tb_otl_unpack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] data_o;
  logic        frame_o;
  logic        pad_err_o;
  logic [2:0]  level_o;

  otl_unpack #(.DEPTH(DEPTH), .SAMPLE_W(12)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .frame_o(frame_o),
    .pad_err_o(pad_err_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] d;
    logic        e_rdy;
    logic        e_frm;
    logic [11:0] e_dat;
    logic [2:0]  e_lvl;
    logic        e_pad;
  } vec_t;

  vec_t tbl [21];

  // Reference model for the hand-written sequences
  logic [31:0] mq [$];
  int          m_cnt = 0;
  int          m_st  = 0;   // 0 idle, 1 hi, 2 lo
  logic [11:0] m_hold = '0;
  logic [11:0] m_dat  = '0;
  logic        m_frm  = 1'b0;
  logic        m_pad  = 1'b0;
  int          max_lvl = 0;
  int          rdy_low = 0;

  task automatic cyc(input logic r, input logic v, input logic [31:0] d);
    logic e_rdy, psh, pp;
    logic [31:0] w;
    rst = r; valid_i = v; data_i = d;
    #1;
    e_rdy = !r && (m_cnt != DEPTH);
    chk("ready", int'(ready_o), int'(e_rdy));
    if (!r && !ready_o) rdy_low++;
    psh = v && e_rdy;
    pp  = !r && (m_st != 1) && (m_cnt != 0);
    if (r) begin
      mq.delete();
      m_cnt = 0; m_st = 0; m_dat = '0; m_frm = 1'b0; m_pad = 1'b0;
    end else begin
      if (psh) mq.push_back(d);
      if (pp) begin
        w = mq.pop_front();
        m_dat = w[27:16]; m_hold = w[11:0]; m_frm = 1'b1; m_st = 1;
        if (w[31:28] != 4'h0 || w[15:12] != 4'h0) m_pad = 1'b1;
      end else if (m_st == 1) begin
        m_dat = m_hold; m_frm = 1'b1; m_st = 2;
      end else begin
        m_dat = '0; m_frm = 1'b0; m_st = 0;
      end
      m_cnt = m_cnt + int'(psh) - int'(pp);
    end
    @(posedge clk);
    #1;
    chk("frame", int'(frame_o), int'(m_frm));
    chk("data",  int'(data_o),  int'(m_dat));
    chk("level", int'(level_o), m_cnt);
    chk("pad",   int'(pad_err_o), int'(m_pad));
    if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
  endtask

  initial begin
    logic fr [16];
    int   rises, min_gap, gap;
    rst = 1'b1; valid_i = 1'b0; data_i = '0;

    //            r  v  data          rdy frm dat     lvl pad
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 12'h000, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0ABC_0123, 1'b1, 1'b0, 12'h000, 3'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'hABC, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h123, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 12'h000, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0111_0222, 1'b1, 1'b0, 12'h000, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0333_0444, 1'b1, 1'b1, 12'h111, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0555_0666, 1'b1, 1'b1, 12'h222, 3'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h333, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h444, 3'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h555, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h666, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 12'h000, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h1000_0000, 1'b1, 1'b0, 12'h000, 3'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h000, 3'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'h000, 3'd0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'h0ABC_0DEF, 1'b1, 1'b0, 12'h000, 3'd1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'hABC, 3'd0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 12'hDEF, 3'd0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 12'h000, 3'd0, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 12'h000, 3'd0, 1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].r; valid_i = tbl[i].v; data_i = tbl[i].d;
      #1;
      chk($sformatf("v%0d_ready", i), int'(ready_o), int'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_frame", i), int'(frame_o),   int'(tbl[i].e_frm));
      chk($sformatf("v%0d_data",  i), int'(data_o),    int'(tbl[i].e_dat));
      chk($sformatf("v%0d_level", i), int'(level_o),   int'(tbl[i].e_lvl));
      chk($sformatf("v%0d_pad",   i), int'(pad_err_o), int'(tbl[i].e_pad));
    end

    // Full FIFO: continuous host for 20 cycles, then drain
    cyc(1'b1, 1'b0, 32'h0);
    max_lvl = 0; rdy_low = 0;
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b1, {4'h0, 12'(i * 3 + 1), 4'h0, 12'(i * 5 + 7)});
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("full_max_level", max_lvl, DEPTH);
    chk("full_ready_dropped", int'(rdy_low > 0), 1);
    chk("full_drained", int'(level_o), 0);

    // Underflow gap between two isolated words
    cyc(1'b0, 1'b1, 32'h0A11_0A22);
    fr[0] = frame_o;
    for (int i = 1; i < 6; i++) begin cyc(1'b0, 1'b0, 32'h0); fr[i] = frame_o; end
    cyc(1'b0, 1'b1, 32'h0B33_0B44);
    fr[6] = frame_o;
    for (int i = 7; i < 16; i++) begin cyc(1'b0, 1'b0, 32'h0); fr[i] = frame_o; end
    rises = 0; min_gap = 99; gap = 0;
    for (int i = 1; i < 16; i++) begin
      if (fr[i] && !fr[i-1]) begin
        rises++;
        if (rises > 1 && gap < min_gap) min_gap = gap;
        gap = 0;
      end
      if (!fr[i]) gap++;
    end
    chk("gap_bursts", rises, 2);
    chk("gap_min_low", int'(min_gap >= 1), 1);

    // Reset during the HI sample of a two-word burst
    cyc(1'b0, 1'b1, 32'h0C55_0C66);
    cyc(1'b0, 1'b1, 32'h0D77_0D88);
    chk("rstmid_in_hi", int'(frame_o), 1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rstmid_frame_low", int'(frame_o), 0);
    chk("rstmid_level", int'(level_o), 0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0E99_0EAA);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otl_unpack.md
Name: otl_unpack

Overview:
- TX-side counterpart of the RX sample packer; turns 32-bit host words into a stream of 12-bit samples for the line transmitter.
- Each word carries two samples: bits [27:16] are sent first, then bits [11:0]. Bits [31:28] and [15:12] are zero pad.
- A small word FIFO with a valid/ready handshake absorbs host burstiness.
- frame_o is high while samples are streaming, so the RX packer pairs the samples back into the same words.

Parameters:
- DEPTH, 4, word FIFO depth in 32-bit words; power of 2, minimum 2.
- SAMPLE_W, 12, sample width; fixed at 12, exposed for documentation and checks only.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_i  input  32  host word {pad4, sampleA[11:0], pad4, sampleB[11:0]}.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  FIFO can accept a word this cycle.
- data_o  output  12  sample to the transmitter; registered.
- frame_o  output  1  data_o holds a valid sample; registered.
- pad_err_o  output  1  sticky flag: a popped word had non-zero pad bits.
- level_o  output  $clog2(DEPTH)+1  current FIFO occupancy in words.

Behaviour:
- Reset (rst high at a clock edge):
  - FIFO pointers and count go to 0; state goes to IDLE.
  - data_o=0, frame_o=0, pad_err_o=0, level_o=0.
  - ready_o is forced to 0 while rst is high.
- Push:
  - A word is accepted at an edge where valid_i & ready_o.
  - ready_o = ~rst & (count != DEPTH), decoded from registered state only; there is no combinational path from valid_i.
  - valid_i while ready_o=0 is ignored; the host must hold the word.
- Pop: occurs internally at an edge where the FSM needs a word and count != 0.
- Count arithmetic:
  - push only: +1; pop only: -1; push and pop on the same edge: unchanged.
  - Pointers wrap modulo DEPTH.
  - A push at count == DEPTH cannot occur, because ready_o is low.
- FSM states are IDLE, HI and LO. State, data_o and frame_o all update on the same edge.
- IDLE:
  - count==0: stay in IDLE; data_o=0, frame_o=0.
  - count!=0: pop the word into the hold register; go to HI; data_o=word[27:16], frame_o=1.
- HI: go to LO; data_o=hold[11:0], frame_o=1.
- LO:
  - count!=0: pop; go to HI; data_o=new[27:16], frame_o=1. Back-to-back words stream with no frame gap.
  - count==0: go to IDLE; data_o=0, frame_o=0.
- Consequences:
  - frame_o bursts always contain an even number of samples, starting with the HI sample.
  - Every underflow produces at least one frame_o-low cycle, so the receiver re-aligns its pairing.
- Latency (word pushed into an empty FIFO at edge k, FSM in IDLE):
  - the HI sample appears after edge k+1;
  - the LO sample appears after edge k+2.
- pad_err_o: set on the pop edge if the popped word has [31:28] != 0 or [15:12] != 0; cleared only by rst. The pad bits are never transmitted.
- Reset mid-burst: the burst is truncated immediately; the next cycle has frame_o=0 and the FIFO contents are discarded.
- Throughput: one sample per clock, so one word per 2 clocks. With a continuous host, the FIFO fills and ready_o toggles.

Test Plan:
- Single word: reset, push 0x0ABC_0123 → after edges k+1 and k+2, data_o=0xABC then 0x123 with frame_o=1; then frame_o=0 and data_o=0.
- Back-to-back streaming: push 3 words with valid_i held high → 6 consecutive frame_o=1 cycles with samples in order (hi0, lo0, hi1, lo1, hi2, lo2) and no gap; level_o returns to 0.
- Full FIFO: hold valid_i=1 for 20 cycles with DEPTH=4 → level_o reaches 4 at most; ready_o drops; no words are lost or duplicated (scoreboard); the push+pop edge leaves level_o unchanged.
- Underflow gap: push word A, wait 5 cycles, push word B → two 2-sample bursts separated by at least 1 cycle with frame_o=0.
- Pad error: push 0x1000_0000 → samples 0x000, 0x000; pad_err_o rises on the pop edge and stays 1 through later clean words until rst.
- Reset mid-burst: assert rst during the HI cycle of a 2-word burst → next cycle frame_o=0, level_o=0, ready_o=0 during rst and 1 after; a subsequent push streams normally.
